muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Executes the R-type functs MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO, which alu_control does not handle.
- Sits beside the ALU and is enabled by the main controller for R-type instructions.
- Drives a stall to the PC/register-file write path while a result is pending.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- mdEn  input  1  current instruction is R-type; qualifies instFunc.
- instFunc  input  6  funct field.
- srcA  input  WIDTH  rs value (multiplicand/dividend, MTHI/MTLO source).
- srcB  input  WIDTH  rt value (multiplier/divisor).
- hiLoOut  output  WIDTH  HI when funct=MFHI, otherwise LO (combinational from registers).
- stall  output  1  current instruction cannot complete this cycle.
- busy  output  1  an operation is in flight.
- done  output  1  one-cycle pulse on the edge HI/LO are written by MULT*/DIV*.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, HI=LO=0, counter=0, busy=0, done=0, stall=0. This aborts any in-flight operation with no HI/LO write.
- Funct codes:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - Any other funct, or mdEn=0, has no effect.
- FSM states: IDLE, RUN, FIXUP.
  - IDLE -> RUN when a MULT* or DIV* is accepted (mdEn=1, stall=0): latch operand magnitudes, sign flags, op kind; counter=0.
  - RUN: one radix-2 step per cycle on a 2*WIDTH working register. MUL uses shift-add; DIV uses restoring shift-subtract. counter increments. RUN -> FIXUP when counter==WIDTH-1.
  - FIXUP: apply sign correction and write HI/LO; done=1 that cycle; -> IDLE.
- busy=1 in RUN and FIXUP, i.e. WIDTH+1 cycles starting the cycle after acceptance.
- Stall rule: stall = mdEn & busy & funct in {any MULT*/DIV*, MFHI, MFLO, MTHI, MTLO}.
  - Stall is combinational and falls in the cycle after FIXUP, when the new HI/LO are visible.
  - A stalled MULT*/DIV* is not accepted until then.
- MTHI/MTLO (not stalled): write srcA into HI or LO at the edge; the other register is unchanged.
- MFHI/MFLO (not stalled): hiLoOut is valid in the same cycle.
- Arithmetic results:
  - MULT: {HI,LO} = srcA*srcB, 2*WIDTH signed product.
  - MULTU: {HI,LO} = the unsigned product.
  - DIV: LO = quotient truncated toward zero; HI = remainder, sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (DIV or DIVU): LO = all ones, HI = srcA. No exception; full latency still applies.
  - DIV of MIN by -1: LO=MIN, HI=0.
  - MIN magnitudes are handled in WIDTH+1-bit magnitude arithmetic, with no overflow of the latch.
- Operand latching: operands are captured at acceptance, so srcA/srcB may change during RUN.
- Back-to-back: a MULT* issued in the cycle after FIXUP is accepted normally.

Decomposition:
- Shared package mips_defs:
  - funct constants, reused by alu_control;
  - md_op_t enum {MD_MUL, MD_MULU, MD_DIV, MD_DIVU};
  - md_state_t {IDLE, RUN, FIXUP}.
- Sub-module muldiv_datapath: operand magnitude/sign prep, working register, per-step add/subtract, FIXUP negation.
- muldiv_unit keeps the FSM, counter, HI/LO registers, stall and decode.

Test Plan:
- MULT srcA=7, srcB=0xFFFFFFFD (-3), then MFLO next cycle -> stall high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulses once.
- DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=1.
- DIVU srcA=0x1234, srcB=0 -> LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then MTHI srcA=0xA5 -> HI=0xA5, LO unchanged, no stall.
- Reset driven low on RUN cycle 10 -> next cycle busy=0, HI=LO=0, done never pulses. A following MULT 3*4 -> LO=12.
- Second MULT issued while busy -> stalled, accepted in the cycle after FIXUP. Non-MD funct (ADD) during busy -> stall=0.

Source files
------------

// File: rtl/mips_defs.sv
// Definitions shared by the R-type decode blocks: funct codes and the
// multiply/divide operation and sequencer state types.
package mips_defs;

   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;

   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   // Values match funct[1:0] of MULT/MULTU/DIV/DIVU so decode is a direct cast.
   typedef enum logic [1:0] {
      MD_MUL  = 2'b00,
      MD_MULU = 2'b01,
      MD_DIV  = 2'b10,
      MD_DIVU = 2'b11
   } md_op_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIXUP
   } md_state_t;

   function automatic logic is_muldiv(input logic [5:0] funct);
      return funct[5:2] == 4'b0110;
   endfunction

   function automatic logic is_hilo_move(input logic [5:0] funct);
      return funct[5:2] == 4'b0100;
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 multiply/divide datapath: operand magnitude prep, 2*WIDTH working
// register with shift-add / restoring shift-subtract, and final sign fixup.
module muldiv_datapath
   import mips_defs::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             step_i,
   input  md_op_t           op_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [2*WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0]   other_q, other_d;
   md_op_t             op_q, op_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic               div0_q, div0_d;

   logic               signed_op, div_op, div_q;
   logic               sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   rem_diff;
   logic               rem_ge;
   logic               neg_res;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign signed_op = (op_i == MD_MUL) || (op_i == MD_DIV);
   assign div_op    = (op_i == MD_DIV) || (op_i == MD_DIVU);
   assign div_q     = (op_q == MD_DIV) || (op_q == MD_DIVU);
   assign sa        = signed_op & src_a_i[WIDTH-1];
   assign sb        = signed_op & src_b_i[WIDTH-1];
   // Unsigned WIDTH-bit magnitude holds |MIN| exactly, so no extra bit is needed.
   assign mag_a     = sa ? -src_a_i : src_a_i;
   assign mag_b     = sb ? -src_b_i : src_b_i;

   assign mul_addend = work_q[0] ? other_q : '0;
   assign mul_sum    = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

   assign rem_sh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   assign rem_ge   = rem_sh >= {1'b0, other_q};
   assign rem_diff = rem_sh[WIDTH-1:0] - other_q;

   always_comb begin
      work_d   = work_q;
      other_d  = other_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      div0_d   = div0_q;
      if (start_i) begin
         op_d     = op_i;
         sign_a_d = sa;
         sign_b_d = sb;
         div0_d   = (src_b_i == '0);
         if (div_op) begin
            work_d  = {{WIDTH{1'b0}}, mag_a};
            other_d = mag_b;
         end else begin
            work_d  = {{WIDTH{1'b0}}, mag_b};
            other_d = mag_a;
         end
      end else if (step_i) begin
         if (div_q)
            work_d = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), work_q[WIDTH-2:0], rem_ge};
         else
            work_d = {mul_sum, work_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         work_q   <= '0;
         other_q  <= '0;
         op_q     <= MD_MUL;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         div0_q   <= 1'b0;
      end else begin
         work_q   <= work_d;
         other_q  <= other_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         div0_q   <= div0_d;
      end
   end

   // Divide by zero leaves quotient all ones and remainder |srcA|; the remainder
   // fixup then restores srcA, so only the quotient negation is suppressed.
   assign neg_res  = sign_a_q ^ sign_b_q;
   assign product  = neg_res ? -work_q : work_q;
   assign quot_fix = (neg_res && !div0_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
   assign rem_fix  = sign_a_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

   assign hi_o = div_q ? rem_fix  : product[2*WIDTH-1:WIDTH];
   assign lo_o = div_q ? quot_fix : product[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: funct decode, IDLE/RUN/FIXUP sequencer,
// iteration counter, architectural HI/LO and pipeline stall.
module muldiv_unit
   import mips_defs::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mdEn,
   input  logic [5:0]       instFunc,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic [WIDTH-1:0] hiLoOut,
   output logic             stall,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   md_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             issue;
   logic             accept;
   logic [WIDTH-1:0] dp_hi, dp_lo;

   assign busy    = (state_q != IDLE);
   assign stall   = mdEn & busy & (is_muldiv(instFunc) | is_hilo_move(instFunc));
   assign issue   = mdEn & ~stall;
   assign accept  = issue & is_muldiv(instFunc);
   assign hiLoOut = (instFunc == FUNCT_MFHI) ? hi_q : lo_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1))
               state_d = FIXUP;
         end
         FIXUP: begin
            done    = 1'b1;
            hi_d    = dp_hi;
            lo_d    = dp_lo;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Moves are stalled while busy, so they never collide with the FIXUP write.
      if (issue && instFunc == FUNCT_MTHI) hi_d = srcA;
      if (issue && instFunc == FUNCT_MTLO) lo_d = srcA;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (accept),
      .step_i  (state_q == RUN),
      .op_i    (md_op_t'(instFunc[1:0])),
      .src_a_i (srcA),
      .src_b_i (srcB),
      .hi_o    (dp_hi),
      .lo_o    (dp_lo)
   );

endmodule
